sw_pe_array_64: RTL and testbench
=================================

Name: sw_pe_array_64

Overview:
- 64-cell linear systolic array that computes Smith-Waterman local-alignment scores (linear gap) for one 64-base stripe of query sequence B against a streamed reference sequence A.
- Sits between the stripe controller, which loads B and streams A, and the stripe-chaining logic.
- Each stripe reports three results: end flag, best-column offset in the last row, and the stripe maximum score.
- The controller starts the next stripe at A index previous_start + o_start_position + 1.

Parameters:
- N_PE, 64, number of processing elements (rows of B per stripe).
- WINDOW, 128, number of A columns evaluated per stripe.
- MATCH, 2, score added on base match.
- MISMATCH, 1, score subtracted on base mismatch.
- GAP, 1, linear gap penalty.
- SW, 14, score width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Asynchronous, active-low.
- i_start  in  1  stream-valid. High means i_A is accepted this cycle; low means idle/clear between stripes.
- i_B  in  128  stripe bases, 2 bits each; bits [2k+1:2k] belong to PE k.
- i_A  in  2  one streamed A base (encoding 0=A, 1=C, 2=G, 3=T).
- o_stripe_end  out  1  stripe complete.
- o_start_position  out  10  0-based A offset (relative to the stripe's first accepted base) of the best last-row column.
- o_max_score_stripe  out  14  maximum H over all cells of the stripe.

Behaviour:
- Reset (i_rst=0, async): all PE H/E/base registers, column counter, o_stripe_end, o_start_position and o_max_score_stripe go to 0.
- While i_start=0:
  - PE k loads i_B[2k+:2] every cycle.
  - All PE H registers and pipeline shift registers clear to 0.
  - Column counter clears to 0.
  - Output registers hold their last values.
- While i_start=1: B is frozen. Each cycle one A base enters PE 0 and shifts one PE per cycle, so PE k sees base j at acceptance cycle j+k.
- Per cell:
  - H(i,j) = max(0, H(i-1,j-1)+s, H(i-1,j)-GAP, H(i,j-1)-GAP).
  - s = +MATCH on equal bases, otherwise -MISMATCH.
  - Row/column boundaries are 0.
  - Arithmetic is signed internally; results are clamped to 0..2^SW-1 (saturate).
- Each PE passes its H, the delayed A base and a valid bit to PE k+1, registered.
- Max tracking:
  - A running maximum over every valid PE output updates o_max_score_stripe.
  - Last-row best: when PE 63 output column j exceeds the stored last-row best (strictly greater, so the earliest column wins ties), store j into o_start_position.
  - If the last row never exceeds 0, o_start_position=0.
- On the first accepted base of a stripe (i_start=1, counter=0): o_max_score_stripe, o_start_position and o_stripe_end clear in the same edge.
- o_stripe_end:
  - Registered; rises on the edge after PE 63 produces column WINDOW-1, i.e. WINDOW+N_PE-1 = 191 accepted cycles.
  - Held high until i_start falls.
  - Bases accepted after completion are ignored (no further score updates).
- i_start dropping mid-stripe aborts the stripe: internal state clears, and outputs hold partial values with o_stripe_end cleared.
- Async reset mid-stripe returns everything to the reset state. The next stripe requires i_start low for at least 1 cycle to load B.

Decomposition:
- Package sw_pkg holds:
  - base_t (2-bit encoding) and score_t (SW-bit).
  - MATCH/MISMATCH/GAP defaults.
  - A function for saturated max/clamp.
- Sub-module sw_pe (one cell):
  - Inputs: own base, A in, H_diag/H_up in, valid in, clear.
  - Outputs: A out, H out, valid out.
- The top instantiates 64 sw_pe via generate. Max tracking, column counter and end logic live in the top.

Test Plan:
- Reset: assert i_rst=0 mid-operation -> all outputs 0 immediately (async), o_stripe_end=0.
- Identical sequences: B=64×0, A=256×0 streamed with i_start=1 -> o_stripe_end rises after 191 accepted bases; o_max_score_stripe=128; o_start_position=63.
- Total mismatch: B=64×0, A all 1 -> o_max_score_stripe=0, o_start_position=0, o_stripe_end after 191 cycles.
- Single-base hit: B[0]=2 (others 3), A[5]=2 (others 0) -> o_max_score_stripe=2; last-row scores are 0, so o_start_position=0.
- Chaining: run stripe 0, then drop i_start for 1 cycle, load new i_B and restream -> outputs clear on the first accepted base, B is reloaded, and results match an independent stripe run.
- Abort: drop i_start after 50 bases -> o_stripe_end stays 0, and the next full stripe gives correct results from zero state.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and scoring defaults for the Smith-Waterman systolic array.
// Scores are computed in a widened signed form and clamped back to score_t.
package sw_pkg;

    localparam int SW           = 14;
    localparam int XW           = SW + 2;
    localparam int DEF_N_PE     = 64;
    localparam int DEF_WINDOW   = 128;
    localparam int DEF_MATCH    = 2;
    localparam int DEF_MISMATCH = 1;
    localparam int DEF_GAP      = 1;

    typedef logic [1:0]           base_t;
    typedef logic [SW-1:0]        score_t;
    typedef logic signed [XW-1:0] wide_t;

    typedef struct packed {
        base_t  a;
        score_t h;
        logic   v;
    } pe_link_t;

    localparam wide_t SCORE_MAX = wide_t'((1 << SW) - 1);

    function automatic score_t sat_max3(input wide_t x, input wide_t y, input wide_t z);
        wide_t m;
        m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        if (m < 0) return '0;
        if (m > SCORE_MAX) return '1;
        return m[SW-1:0];
    endfunction

endpackage

// File: rtl/sw_pe.sv
// One Smith-Waterman cell: owns one base of B and produces one row of H,
// forwarding the A base, its H and a valid bit to the next cell.
module sw_pe
    import sw_pkg::*;
#(
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_clr,
    input  base_t    i_b,
    input  pe_link_t i_link,
    output pe_link_t o_link,
    output score_t   o_h_cell
);

    base_t  b_q;
    base_t  a_q;
    score_t h_q;
    score_t hd_q;
    logic   v_q;

    wide_t  s;
    wide_t  diag;
    wide_t  up;
    wide_t  left;
    score_t h_d;

    // hd_q is the upstream H from one cycle ago, i.e. H(i-1, j-1).
    always_comb begin
        s    = (i_link.a == b_q) ? wide_t'(MATCH) : -wide_t'(MISMATCH);
        diag = wide_t'(hd_q) + s;
        up   = wide_t'(i_link.h) - wide_t'(GAP);
        left = wide_t'(h_q) - wide_t'(GAP);
        h_d  = sat_max3(diag, up, left);
    end

    assign o_h_cell = i_link.v ? h_d : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            b_q  <= '0;
            a_q  <= '0;
            h_q  <= '0;
            hd_q <= '0;
            v_q  <= 1'b0;
        end else if (i_clr) begin
            b_q  <= i_b;
            a_q  <= '0;
            h_q  <= '0;
            hd_q <= '0;
            v_q  <= 1'b0;
        end else begin
            a_q  <= i_link.a;
            v_q  <= i_link.v;
            hd_q <= i_link.h;
            if (i_link.v) h_q <= h_d;
        end
    end

    assign o_link = '{a: a_q, h: h_q, v: v_q};

endmodule

// File: rtl/sw_pe_array_64.sv
// Linear systolic array scoring one stripe of B against streamed A,
// with stripe-wide max, last-row best column and end-of-stripe tracking.
module sw_pe_array_64
    import sw_pkg::*;
#(
    parameter int N_PE     = DEF_N_PE,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2*N_PE-1:0] i_B,
    input  base_t             i_A,
    output logic              o_stripe_end,
    output logic [9:0]        o_start_position,
    output score_t            o_max_score_stripe
);

    localparam int LAST = WINDOW + N_PE - 1;
    localparam int CW   = $clog2(LAST + 1);
    localparam int PW   = 10;

    pe_link_t link [N_PE+1];
    score_t   cell_h [N_PE];

    logic [CW-1:0] cnt_q, cnt_d;
    logic          end_q, end_d;
    logic [PW-1:0] pos_q, pos_d;
    score_t        max_q, max_d;
    score_t        best_q, best_d;

    score_t        cur_max;
    logic          first;
    logic [PW-1:0] col;
    logic          unused_tail;

    // Only the first WINDOW accepted bases are marked valid into the array.
    assign link[0] = '{a: i_A, h: '0, v: i_start && (cnt_q < CW'(WINDOW))};

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        sw_pe #(
            .MATCH    (MATCH),
            .MISMATCH (MISMATCH),
            .GAP      (GAP)
        ) u_pe (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clr    (!i_start),
            .i_b      (i_B[2*k +: 2]),
            .i_link   (link[k]),
            .o_link   (link[k+1]),
            .o_h_cell (cell_h[k])
        );
    end

    assign unused_tail = ^link[N_PE];

    always_comb begin
        cur_max = '0;
        for (int k = 0; k < N_PE; k++) begin
            if (cell_h[k] > cur_max) cur_max = cell_h[k];
        end

        first = i_start && (cnt_q == '0);
        col   = PW'(cnt_q) - PW'(N_PE - 1);

        cnt_d  = cnt_q;
        end_d  = end_q;
        pos_d  = first ? '0 : pos_q;
        max_d  = first ? '0 : max_q;
        best_d = first ? '0 : best_q;

        if (!i_start) begin
            cnt_d  = '0;
            end_d  = 1'b0;
            best_d = '0;
        end else begin
            if (cnt_q != CW'(LAST)) cnt_d = cnt_q + 1'b1;
            if (first) end_d = 1'b0;
            if (cnt_q == CW'(LAST - 1)) end_d = 1'b1;
            if (cur_max > max_d) max_d = cur_max;
            // Strictly greater keeps the earliest column on ties.
            if (link[N_PE-1].v && (cell_h[N_PE-1] > best_d)) begin
                best_d = cell_h[N_PE-1];
                pos_d  = col;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q  <= '0;
            end_q  <= 1'b0;
            pos_q  <= '0;
            max_q  <= '0;
            best_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            end_q  <= end_d;
            pos_q  <= pos_d;
            max_q  <= max_d;
            best_q <= best_d;
        end
    end

    assign o_stripe_end       = end_q;
    assign o_start_position   = pos_q;
    assign o_max_score_stripe = max_q;

endmodule

// File: tb/tb_sw_pe_array_64.sv
// Directed bench for sw_pe_array_64 with hand-computed stripe results.
module tb_sw_pe_array_64;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] b_vec = '0;
    logic [1:0]   a_in  = '0;
    logic         end_o;
    logic [9:0]   pos_o;
    logic [13:0]  max_o;

    logic [1:0] a_seq [256];
    int n_cmp = 0;
    int n_bad = 0;
    int acc   = 0;

    sw_pe_array_64 dut (
        .i_clk              (clk),
        .i_rst              (rst_n),
        .i_start            (start),
        .i_B                (b_vec),
        .i_A                (a_in),
        .o_stripe_end       (end_o),
        .o_start_position   (pos_o),
        .o_max_score_stripe (max_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = 1'b0;
        acc   = 0;
        tick();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            a_in  = a_seq[acc % 256];
            start = 1'b1;
            tick();
            acc++;
            if (acc == 190) chk("end_early", end_o, 0);
            if (acc == 191) chk("end_rise", end_o, 1);
        end
    endtask

    task automatic set_b(input int first, input int rest);
        for (int k = 0; k < 64; k++)
            b_vec[2*k +: 2] = (k == 0) ? first[1:0] : rest[1:0];
    endtask

    task automatic set_a(input int n_head, input int head, input int tail);
        for (int i = 0; i < 256; i++)
            a_seq[i] = (i < n_head) ? head[1:0] : tail[1:0];
    endtask

    initial begin
        set_b(0, 0);
        set_a(0, 0, 0);
        repeat (2) tick();
        chk("rst_end", end_o, 0);
        chk("rst_pos", pos_o, 0);
        chk("rst_max", max_o, 0);
        rst_n = 1'b1;

        // identical sequences
        idle();
        stream(256);
        chk("same_end", end_o, 1);
        chk("same_max", max_o, 128);
        chk("same_pos", pos_o, 63);

        // async reset while streaming
        #2 rst_n = 1'b0;
        #1;
        chk("arst_end", end_o, 0);
        chk("arst_pos", pos_o, 0);
        chk("arst_max", max_o, 0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;

        // total mismatch
        set_b(0, 0);
        set_a(0, 1, 1);
        idle();
        stream(200);
        chk("mis_end", end_o, 1);
        chk("mis_max", max_o, 0);
        chk("mis_pos", pos_o, 0);

        // single-base hit in row 0
        set_b(2, 3);
        set_a(0, 0, 0);
        a_seq[5] = 2'd2;
        idle();
        stream(200);
        chk("hit_end", end_o, 1);
        chk("hit_max", max_o, 2);
        chk("hit_pos", pos_o, 0);

        // chaining: full stripe, then reload B and restream
        set_b(0, 0);
        set_a(0, 0, 0);
        idle();
        stream(191);
        chk("ch0_max", max_o, 128);
        chk("ch0_pos", pos_o, 63);
        set_b(1, 1);
        set_a(10, 0, 1);
        idle();
        chk("ch_gap_end", end_o, 0);
        chk("ch_gap_max", max_o, 128);
        chk("ch_gap_pos", pos_o, 63);
        stream(1);
        chk("ch1_clr_max", max_o, 0);
        chk("ch1_clr_pos", pos_o, 0);
        stream(199);
        chk("ch1_end", end_o, 1);
        chk("ch1_max", max_o, 128);
        chk("ch1_pos", pos_o, 73);

        // abort after 50 bases
        set_b(0, 0);
        set_a(0, 0, 0);
        idle();
        stream(50);
        chk("ab_end", end_o, 0);
        chk("ab_max", max_o, 50);
        chk("ab_pos", pos_o, 0);
        idle();
        chk("ab_idle_end", end_o, 0);
        chk("ab_idle_max", max_o, 50);
        set_a(10, 1, 0);
        stream(200);
        chk("ab_next_end", end_o, 1);
        chk("ab_next_max", max_o, 128);
        chk("ab_next_pos", pos_o, 73);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
